// File: rtl/mod_74x161_if.sv
// mod_74x161_if
// Bus bundle for the 74x161-style counter.
//   ld_n : synchronous parallel load, active-low
//   enp  : count enable P (gates counting only)
//   ent  : count enable T (gates counting and the ripple carry)
//   d    : parallel load data, W bits, bits [3:0] belong to the LSB section
//   q    : counter state, W bits
//   rco  : ripple carry out of the top section, combinational
// The master drives controls and data; the slave is the counter itself.
interface mod_74x161_if #(
    parameter int W = 4
);
    logic         ld_n;
    logic         enp;
    logic         ent;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         rco;

    modport master (
        output ld_n, enp, ent, d,
        input  q, rco
    );

    modport slave (
        input  ld_n, enp, ent, d,
        output q, rco
    );
endinterface

// File: rtl/mod_74x161.sv
// mod_74x161
// Synchronous presettable binary counter built from STAGES cascaded 4-bit
// sections, each behaving like one 74x161 with its RCO feeding the next
// section's ENT (carry-lookahead chaining). Clear is asynchronous and
// active-high; load, count and hold happen at the rising clock edge.
// Ports:
//   clk : counter clock, rising-edge active
//   rst : asynchronous active-high clear, forces q to zero immediately
//   bus : mod_74x161_if slave (ld_n, enp, ent, d in; q, rco out)
// STAGES is meaningful over 1..8, giving a counter width of 4*STAGES.
module mod_74x161 #(
    parameter int STAGES = 1
) (
    input  logic           clk,
    input  logic           rst,
    mod_74x161_if.slave    bus
);
    localparam int W = 4 * STAGES;

    logic [W-1:0]    q_q;
    logic [W-1:0]    q_d;
    logic [STAGES:0] t;

    // Carry chain: t[k] is the ENT seen by section k. A section passes the
    // enable upward only while it sits at F, so t[STAGES] is exactly the
    // top section's RCO, i.e. ent AND (q == all ones).
    always_comb begin
        t    = '0;
        t[0] = bus.ent;
        for (int k = 0; k < STAGES; k++) begin
            t[k+1] = t[k] && (q_q[4*k +: 4] == 4'hF);
        end
    end

    // Next state: load beats counting and ignores both enables. Otherwise
    // each section increments on its own when ENP and its chained T are
    // high; a section at F wraps to 0 on its own 4-bit add.
    always_comb begin
        q_d = q_q;
        if (!bus.ld_n) begin
            q_d = bus.d;
        end else if (bus.enp) begin
            for (int k = 0; k < STAGES; k++) begin
                if (t[k]) begin
                    q_d[4*k +: 4] = q_q[4*k +: 4] + 4'd1;
                end
            end
        end
    end

    // State register; clear acts without a clock and masks every edge
    // while it is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.q   = q_q;
    assign bus.rco = t[STAGES];
endmodule
